// File: rtl/iterative_muldiv_if.sv
// Register-file side bundle of the iterative multiply/divide unit.
// master drives the request and operands; slave returns the write-port signals.
interface iterative_muldiv_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
);
  // Handshake: a request is taken only when start is high on an edge while busy is low;
  // start seen while busy is high is dropped, and load is a one-cycle write strobe with no back-pressure.
  logic              start;
  logic [1:0]        op;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic [ADDR_W-1:0] dest;
  logic              busy;
  logic [WIDTH-1:0]  C;
  logic [ADDR_W-1:0] Caddr;
  logic              load;
  logic              div_by_zero;

  modport master (
    output start, op, A, B, dest,
    input  busy, C, Caddr, load, div_by_zero
  );

  modport slave (
    input  start, op, A, B, dest,
    output busy, C, Caddr, load, div_by_zero
  );
endinterface

// File: rtl/iterative_muldiv.sv
// One-bit-per-cycle unsigned multiply (and, with MULDIV_DIV_EN defined, restoring divide)
// that writes its result to the register file through C/Caddr/load.
module iterative_muldiv #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 clear,
  iterative_muldiv_if.slave    bus,
  output logic [1:0]           dbg_state
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t              state;
  logic [2*WIDTH-1:0]  acc;
  logic [2*WIDTH-1:0]  acc_next;
  logic [WIDTH-1:0]    opnd;
  logic [WIDTH:0]      mul_sum;
  logic [WIDTH-1:0]    result_next;
  logic [ADDR_W-1:0]   dest_q;
  logic [CW-1:0]       cnt;
  logic                hi_sel;
`ifdef MULDIV_DIV_EN
  logic                is_div;
  logic                dz_q;
  logic [WIDTH:0]      div_shift;
  logic [WIDTH:0]      div_diff;
`endif

  assign dbg_state = state;
  assign bus.busy  = (state != IDLE);

  // acc holds {high, low}: for MUL the low half starts as the multiplier and shifts out,
  // for DIV the high half is the partial remainder and the low half turns into the quotient.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    acc_next = {mul_sum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (is_div) begin
      if (div_shift >= {1'b0, opnd})
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
`endif
    // High half is MULHI or REM, low half is MULLO or DIV.
    result_next = hi_sel ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state           <= IDLE;
      acc             <= '0;
      opnd            <= '0;
      dest_q          <= '0;
      cnt             <= '0;
      hi_sel          <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div          <= 1'b0;
      dz_q            <= 1'b0;
`endif
      bus.C           <= '0;
      bus.Caddr       <= '0;
      bus.load        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.load        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dest_q <= bus.dest;
            hi_sel <= bus.op[0];
            cnt    <= CNT_INIT;
            acc    <= {{WIDTH{1'b0}}, bus.B};
            opnd   <= bus.A;
`ifdef MULDIV_DIV_EN
            is_div <= bus.op[1];
            dz_q   <= bus.op[1] && (bus.B == '0);
            if (bus.op[1]) begin
              acc  <= {{WIDTH{1'b0}}, bus.A};
              opnd <= bus.B;
            end
`endif
            state  <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DONE;
            bus.C     <= result_next;
            bus.Caddr <= dest_q;
            bus.load  <= 1'b1;
`ifdef MULDIV_DIV_EN
            bus.div_by_zero <= dz_q;
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iterative_muldiv.sv
// Randomized self-checking bench for iterative_muldiv; honours MULDIV_DIV_EN the same way the RTL does.
module tb_iterative_muldiv;
  localparam int W  = 16;
  localparam int AW = 4;
  localparam int LAT = 17;
  // Expected-entry layout: {load cycle, div_by_zero, address, data}
  localparam int EW = 32 + 1 + AW + W;

  logic clk = 1'b0;
  logic clear;
  logic [1:0] dbg_state;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int busy_lo = 0;
  int busy_hi = -1;
  logic [W-1:0]  last_c = '0;
  logic [AW-1:0] last_a = '0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;
  logic          exp_load;
  logic          exp_dz;

  iterative_muldiv_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

  iterative_muldiv #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk       (clk),
    .clear     (clear),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] c, output logic dz);
    logic [2*W-1:0] p;
    p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    dz = 1'b0;
    c  = op[0] ? p[2*W-1:W] : p[W-1:0];
`ifdef MULDIV_DIV_EN
    if (op[1]) begin
      if (b == '0) begin
        dz = 1'b1;
        c  = op[0] ? a : '1;
      end else begin
        c  = op[0] ? (a % b) : (a / b);
      end
    end
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic scramble();
    bus.op   = 2'($urandom_range(0, 3));
    bus.A    = W'($urandom);
    bus.B    = W'($urandom);
    bus.dest = AW'($urandom);
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [AW-1:0] d);
    logic [W-1:0] c;
    logic dz;
    model(op, a, b, c, dz);
    bus.start = 1'b1;
    bus.op = op; bus.A = a; bus.B = b; bus.dest = d;
    exp_q.push_back({32'(cyc + LAT), dz, d, c});
    busy_lo = cyc + 1;
    busy_hi = cyc + LAT;
    tick();
    bus.start = 1'b0;
    scramble();
  endtask

  task automatic poke_start();
    bus.start = 1'b1;
    scramble();
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_clear(input logic with_start);
    clear = 1'b1;
    bus.start = with_start;
    exp_q.delete();
    if (busy_hi > cyc) busy_hi = cyc;
    last_c = '0;
    last_a = '0;
    tick();
    clear = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic run_lit(input string name, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [AW-1:0] d,
                         input logic [W-1:0] lit_c, input logic lit_dz);
    issue(op, a, b, d);
    repeat (LAT - 1) tick();
    chk({name, "_load"}, 32'(bus.load), 32'd1);
    chk({name, "_C"}, 32'(bus.C), 32'(lit_c));
    chk({name, "_Caddr"}, 32'(bus.Caddr), 32'(d));
    chk({name, "_dz"}, 32'(bus.div_by_zero), 32'(lit_dz));
    tick();
  endtask

  // ---------------- scoreboard / per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      exp_load = 1'b0;
      exp_dz   = 1'b0;
      while (exp_q.size() > 0 && int'(exp_q[0][EW-1:EW-32]) < cyc) begin
        e = exp_q.pop_front();
        chk("missed_load", 32'd0, 32'd1);
      end
      if (exp_q.size() > 0 && int'(exp_q[0][EW-1:EW-32]) == cyc) begin
        e = exp_q.pop_front();
        exp_load = 1'b1;
        exp_dz   = e[W+AW];
        last_c   = e[W-1:0];
        last_a   = e[W+AW-1:W];
      end
      chk("load", 32'(bus.load), 32'(exp_load));
      chk("busy", 32'(bus.busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      chk("div_by_zero", 32'(bus.div_by_zero), 32'(exp_dz));
      chk("C", 32'(bus.C), 32'(last_c));
      chk("Caddr", 32'(bus.Caddr), 32'(last_a));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    clear = 1'b1;
    bus.start = 1'b0;
    bus.op = '0; bus.A = '0; bus.B = '0; bus.dest = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_load", 32'(bus.load), 32'd0);
    chk("rst_dz", 32'(bus.div_by_zero), 32'd0);
    chk("rst_C", 32'(bus.C), 32'd0);
    chk("rst_Caddr", 32'(bus.Caddr), 32'd0);
    clear = 1'b0;
    chk_en = 1'b1;
    tick();

    run_lit("mullo_1234", 2'b00, 16'h1234, 16'h0010, 4'd5, 16'h2340, 1'b0);
    run_lit("mulhi_1234", 2'b01, 16'h1234, 16'h0010, 4'd5, 16'h0001, 1'b0);
    run_lit("mulhi_ffff", 2'b01, 16'hFFFF, 16'hFFFF, 4'd3, 16'hFFFE, 1'b0);
    run_lit("mullo_ffff", 2'b00, 16'hFFFF, 16'hFFFF, 4'd0, 16'h0001, 1'b0);
`ifdef MULDIV_DIV_EN
    run_lit("div_1000_7", 2'b10, 16'd1000, 16'd7, 4'd15, 16'h008E, 1'b0);
    run_lit("rem_1000_7", 2'b11, 16'd1000, 16'd7, 4'd15, 16'h0006, 1'b0);
    run_lit("div_by_0", 2'b10, 16'h00AB, 16'h0000, 4'd2, 16'hFFFF, 1'b1);
    run_lit("rem_by_0", 2'b11, 16'h00AB, 16'h0000, 4'd2, 16'h00AB, 1'b1);
`else
    run_lit("op10_as_mullo", 2'b10, 16'd3, 16'd5, 4'd7, 16'h000F, 1'b0);
    run_lit("op11_as_mulhi", 2'b11, 16'hFFFF, 16'hFFFF, 4'd7, 16'hFFFE, 1'b0);
`endif

    // Starts during RUN are ignored; the first result is written once.
    issue(2'b00, 16'h0102, 16'h0304, 4'd9);
    repeat (2) tick();
    poke_start();
    repeat (12) tick();
    poke_start();
    tick();

    // Clear mid-operation aborts it with no write.
    issue(2'b01, 16'hBEEF, 16'h1234, 4'd11);
    repeat (6) tick();
    pulse_clear(1'b0);
    chk("clr_busy", 32'(bus.busy), 32'd0);
    chk("clr_C", 32'(bus.C), 32'd0);
    chk("clr_Caddr", 32'(bus.Caddr), 32'd0);
    repeat (20) tick();

    // Clear together with start drops the request.
    pulse_clear(1'b1);
    chk("clr_start_busy", 32'(bus.busy), 32'd0);
    repeat (3) tick();

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        2: b = W'(1);
        default: b = W'($urandom);
      endcase
      if ($urandom_range(0, 5) == 0) a = '1;
      issue(2'($urandom_range(0, 3)), a, b, AW'($urandom));
      repeat (LAT - 1) tick();
      repeat ($urandom_range(1, 3)) tick();
    end

    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
